image_loader: RTL and testbench

Upstream feeder for the skeletonization core. Accepts a raster-order pixel stream over a valid/ready handshake, buffers it in a small FIFO and replays it as one-cycle write pulses plus pixel data into the core's image-memory write port (`we` / `data_in`). Exactly N*N pixels are written per frame. Optional binarization is applied before writing. The core's address counter advances on every write, so this block guarantees one write per pixel, in order, with no gaps in addressing.

---
 rtl/image_loader.sv | 164 ++++++++++++++++
 tb/tb_image_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Stream-to-core image loader: buffers a raster pixel stream and replays exactly N*N write pulses per frame.
// Optional binarization before the write is enabled by defining IMAGE_LOADER_THRESHOLD_EN.
module image_loader #(
    parameter int unsigned N          = 8,
    parameter int unsigned bitSize    = 6,
    parameter int unsigned pixelWidth = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned THRESH     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  s_valid,
    input  logic [pixelWidth-1:0] s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [pixelWidth-1:0] data_out,
    output logic [bitSize:0]      pix_count,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CNT_W  = bitSize + 1;
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(N * N);

    // Elaboration-time parameter sanity
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("image_loader: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if ((64'(N) * 64'(N)) >= (64'd1 << CNT_W)) begin : g_bad_count
        $error("image_loader: N*N does not fit in bitSize+1 bits");
    end
    if (64'(THRESH) >= (64'd1 << pixelWidth)) begin : g_bad_thresh
        $error("image_loader: THRESH does not fit in pixelWidth bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    start_frame;
    logic [CNT_W-1:0]        acc_cnt;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [pixelWidth-1:0]   mem [FIFO_DEPTH];
    logic [pixelWidth-1:0]   head;
    logic [pixelWidth-1:0]   pix_f;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    // Full when the wrap bits differ and the index bits match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign head       = mem[rd_ptr[ADDR_W-1:0]];

`ifdef IMAGE_LOADER_THRESHOLD_EN
    assign pix_f = {pixelWidth{head >= pixelWidth'(THRESH)}};
`else
    assign pix_f = head;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the combinational handshake and status flags
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        s_ready     = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_frame = 1'b1;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                s_ready = !fifo_full && (acc_cnt < FRAME_PIX);
                push    = s_valid && s_ready;
                pop     = !fifo_empty && !stall;
                if (pix_count == FRAME_PIX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FIFO pointers and frame counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            acc_cnt   <= '0;
            pix_count <= '0;
        end else if (start_frame) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            acc_cnt   <= '0;
            pix_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (acc_cnt < FRAME_PIX) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (pix_count < FRAME_PIX) begin
                    pix_count <= pix_count + CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= s_data;
        end
    end

    // Registered write port toward the core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we       <= 1'b0;
            data_out <= '0;
        end else begin
            we <= pop;
            if (pop) begin
                data_out <= pix_f;
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader: streaming, backpressure, overrun, ignored start, mid-frame reset.
module tb_image_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       we;
    logic [7:0] data_out;
    logic [6:0] pix_count;
    logic       busy;
    logic       frame_done;

    image_loader #(
        .N(8), .bitSize(6), .pixelWidth(8), .FIFO_DEPTH(4), .THRESH(128)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .we(we), .data_out(data_out), .pix_count(pix_count),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;
    int src_idx = 0;
    int src_lim = 0;
    int wr_cnt, first_we, last_we, fd_cnt, fd_cyc, acc_cyc;
    logic [7:0] exp_q[$];
    logic [7:0] wlog [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] src_val(input int idx);
        case (idx)
            200:     return 8'd127;
            201:     return 8'd128;
            202:     return 8'd255;
            203:     return 8'd0;
            default: return 8'(idx);
        endcase
    endfunction

    function automatic logic [7:0] exp_f(input logic [7:0] p);
`ifdef IMAGE_LOADER_THRESHOLD_EN
        return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    task automatic src_set(input int idx, input int lim);
        src_idx = idx;
        src_lim = lim;
        s_valid = (src_idx < src_lim);
        s_data  = src_val(src_idx);
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        first_we = -1;
        last_we  = -1;
        fd_cnt   = 0;
        fd_cyc   = -1;
    endtask

    // One clock: log acceptance, advance, then check any write against the expected queue
    task automatic cyc();
        logic acc;
        logic [7:0] e;
        acc = s_valid && s_ready;
        if (acc) exp_q.push_back(exp_f(s_data));
        @(posedge clk);
        #1;
        cyc_n++;
        if (acc) src_idx++;
        s_valid = (src_idx < src_lim);
        s_data  = src_val(src_idx);
        if (we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("write_without_accept", 32'(we), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e));
            end
            check("pix_count", 32'(pix_count), 32'(wr_cnt));
            if (wr_cnt <= 64) wlog[wr_cnt-1] = data_out;
            if (first_we < 0) first_we = cyc_n;
            last_we = cyc_n;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc_n;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        s_valid = 1'b0; s_data = 8'd0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(we), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_pix", 32'(pix_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(frame_done), 32'(0));
        check("rst_ready", 32'(s_ready), 32'(0));
        rst = 1'b0;
        cyc();
        check("idle_ready", 32'(s_ready), 32'(0));

        // Frame 1: 64 back-to-back pixels, no stall
        start = 1'b1; cyc(); start = 1'b0;
        check("f1_busy", 32'(busy), 32'(1));
        check("f1_ready", 32'(s_ready), 32'(1));
        check("f1_pix0", 32'(pix_count), 32'(0));
        clear_stats();
        src_set(0, 64);
        cyc();
        acc_cyc = cyc_n;
        check("f1_lat_we0", 32'(we), 32'(0));
        cyc();
        check("f1_lat_we1", 32'(we), 32'(1));
        check("f1_first_data", 32'(data_out), 32'(0));
        for (int i = 0; i < 200 && fd_cnt == 0; i++) cyc();
        check("f1_done_seen", 32'(fd_cnt), 32'(1));
        check("f1_writes", 32'(wr_cnt), 32'(64));
        check("f1_first_lat", 32'(first_we - acc_cyc), 32'(1));
        check("f1_contig", 32'(last_we - first_we), 32'(63));
        check("f1_done_after_last", 32'(fd_cyc - last_we), 32'(1));
        check("f1_busy_done", 32'(busy), 32'(0));
        check("f1_pix64", 32'(pix_count), 32'(64));
        check("f1_last_data", 32'(wlog[63]), 32'(exp_f(8'd63)));
        repeat (2) cyc();
        check("f1_done_once", 32'(fd_cnt), 32'(1));
        check("f1_queue_empty", 32'(exp_q.size()), 32'(0));

        // Frame 2: ignored start in LOAD, 5-cycle stall, 70-pixel overrun source
        start = 1'b1; cyc(); start = 1'b0;
        clear_stats();
        src_set(0, 70);
        repeat (10) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("f2_start_ign_pix", 32'(pix_count), 32'(10));
        check("f2_start_ign_busy", 32'(busy), 32'(1));
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_we", 32'(we), 32'(0));
            check("bp_ready", 32'(s_ready), 32'((i < 2) ? 1 : 0));
        end
        check("bp_pix_hold", 32'(pix_count), 32'(10));
        stall = 1'b0;
        cyc();
        check("bp_release_we", 32'(we), 32'(1));
        check("bp_release_ready", 32'(s_ready), 32'(1));
        for (int i = 0; i < 200 && fd_cnt == 0; i++) begin
            cyc();
            if (busy) check("ovr_ready", 32'(s_ready), 32'(src_idx < 64));
        end
        check("f2_done_seen", 32'(fd_cnt), 32'(1));
        check("f2_writes", 32'(wr_cnt), 32'(64));
        check("f2_accepted", 32'(src_idx), 32'(64));
        start = 1'b1; cyc(); start = 1'b0;
        check("f2_done_start_busy", 32'(busy), 32'(0));
        check("f2_done_start_ready", 32'(s_ready), 32'(0));
        repeat (3) cyc();
        check("f2_no_extra_frame", 32'(busy), 32'(0));
        check("f2_no_extra_writes", 32'(wr_cnt), 32'(64));
        check("f2_done_once", 32'(fd_cnt), 32'(1));
        check("f2_pix_kept", 32'(pix_count), 32'(64));

        // Frame 3: starts with the pixel left on the stream, reset after 10 writes
        src_set(64, 128);
        start = 1'b1; cyc(); start = 1'b0;
        clear_stats();
        for (int i = 0; i < 50 && wr_cnt < 10; i++) cyc();
        check("f3_ten_writes", 32'(wr_cnt), 32'(10));
`ifdef IMAGE_LOADER_THRESHOLD_EN
        check("f3_first_is_pix64", 32'(wlog[0]), 32'(8'h00));
`else
        check("f3_first_is_pix64", 32'(wlog[0]), 32'(8'h40));
`endif
        rst = 1'b1;
        #1;
        check("mr_we", 32'(we), 32'(0));
        check("mr_data", 32'(data_out), 32'(0));
        check("mr_pix", 32'(pix_count), 32'(0));
        check("mr_busy", 32'(busy), 32'(0));
        check("mr_done", 32'(frame_done), 32'(0));
        check("mr_ready", 32'(s_ready), 32'(0));
        exp_q.delete();
        cyc();
        rst = 1'b0;
        cyc();
        check("mr_idle_busy", 32'(busy), 32'(0));
        check("mr_idle_ready", 32'(s_ready), 32'(0));

        // Frame 4: full frame after reset; leading pixels probe the threshold boundary
        src_set(200, 264);
        start = 1'b1; cyc(); start = 1'b0;
        clear_stats();
        for (int i = 0; i < 200 && fd_cnt == 0; i++) cyc();
        check("f4_done_seen", 32'(fd_cnt), 32'(1));
        check("f4_writes", 32'(wr_cnt), 32'(64));
        check("f4_pix64", 32'(pix_count), 32'(64));
`ifdef IMAGE_LOADER_THRESHOLD_EN
        check("th_127", 32'(wlog[0]), 32'(8'h00));
        check("th_128", 32'(wlog[1]), 32'(8'hFF));
        check("th_255", 32'(wlog[2]), 32'(8'hFF));
        check("th_0", 32'(wlog[3]), 32'(8'h00));
`else
        check("raw_127", 32'(wlog[0]), 32'(8'h7F));
        check("raw_128", 32'(wlog[1]), 32'(8'h80));
        check("raw_255", 32'(wlog[2]), 32'(8'hFF));
        check("raw_0", 32'(wlog[3]), 32'(8'h00));
`endif
        check("f4_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
